// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: data-memory initiator for loads/stores on a word-wide port.
// Sub-word stores are done as read-modify-write; sub-word loads are lane-extracted and extended.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       load_data,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [31:0]       mem_write_data,
  output logic              mem_read_signal,
  output logic              mem_write_signal,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_ready
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [2:0]        req_op;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       rmw_word;

  logic              in_half;
  logic              in_word;
  logic              misaligned;
  logic              req_is_load;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_ext;
  logic [31:0]       store_word;

  // Address bits above the memory size wrap and are intentionally dropped.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_W+2];

  always_comb begin
    in_half    = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    in_word    = (op == OP_LW) || (op == OP_SW);
    misaligned = (in_half && address[0]) || (in_word && (address[1:0] != 2'b00));
  end

  assign req_is_load = (req_op <= OP_LHU);

  always_comb begin
    lane_byte = mem_read_data[{req_addr[1:0], 3'b000} +: 8];
    lane_half = mem_read_data[{req_addr[1], 4'b0000} +: 16];
    case (req_op)
      OP_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
      OP_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
      OP_LBU:  load_ext = {24'h000000, lane_byte};
      OP_LHU:  load_ext = {16'h0000, lane_half};
      default: load_ext = mem_read_data;
    endcase
  end

  // Merge the store lane(s) into the word captured during the read phase.
  always_comb begin
    store_word = rmw_word;
    case (req_op)
      OP_SB:   store_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      OP_SH:   store_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      default: store_word = req_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    busy             = 1'b0;
    done             = 1'b0;
    mem_read_signal  = 1'b0;
    mem_write_signal = 1'b0;
    mem_adress       = '0;
    mem_write_data   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (misaligned) begin
            next_state = DONE;
          end else if (op == OP_SW) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: begin
        busy            = 1'b1;
        mem_read_signal = 1'b1;
        mem_adress      = req_addr[ADDR_W+1:2];
        if (mem_ready) begin
          next_state = req_is_load ? DONE : WR;
        end
      end
      WR: begin
        busy             = 1'b1;
        mem_write_signal = 1'b1;
        mem_adress       = req_addr[ADDR_W+1:2];
        mem_write_data   = store_word;
        if (mem_ready) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_op    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      rmw_word  <= '0;
      load_data <= '0;
      error     <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        req_op    <= op;
        req_addr  <= address[ADDR_W+1:0];
        req_wdata <= write_data;
      end
      if ((state == RD) && mem_ready) begin
        if (req_is_load) begin
          load_data <= load_ext;
        end else begin
          rmw_word <= mem_read_data;
        end
      end
      // Only a jump straight from IDLE to DONE is an alignment failure.
      if (next_state == DONE) begin
        error <= (state == IDLE);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: directed vector table, multi-cycle corner sequences and
// randomized traffic against a word-array reference model.
module tb_load_store_unit;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        op = 3'd0;
  logic [31:0]       address = 32'h0;
  logic [31:0]       write_data = 32'h0;
  logic              busy;
  logic              done;
  logic              error;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] mem_adress;
  logic [31:0]       mem_write_data;
  logic              mem_read_signal;
  logic              mem_write_signal;
  logic [31:0]       mem_read_data;
  logic              mem_ready;

  logic              rand_mode = 1'b0;
  logic              rnd_ready = 1'b1;
  logic              man_ready = 1'b1;

  logic [31:0]       mem [256];
  int                rd_cnt = 0;
  int                wr_cnt = 0;
  int                viol = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  logic [31:0]       last_wdata = '0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .op               (op),
    .address          (address),
    .write_data       (write_data),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .load_data        (load_data),
    .mem_adress       (mem_adress),
    .mem_write_data   (mem_write_data),
    .mem_read_signal  (mem_read_signal),
    .mem_write_signal (mem_write_signal),
    .mem_read_data    (mem_read_data),
    .mem_ready        (mem_ready)
  );

  always #5 clk = ~clk;

  assign mem_ready     = rand_mode ? rnd_ready : man_ready;
  assign mem_read_data = mem[mem_adress];

  always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

  // Memory model plus protocol monitor (both strobes high, unstable pending access).
  initial begin : memory_model
    logic              pend;
    logic              p_rd;
    logic              p_wr;
    logic [ADDR_W-1:0] p_a;
    logic [31:0]       p_d;
    pend = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_a = '0; p_d = '0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      mem[i] = {b, ~b, b ^ 8'h5A, 8'hC3};
    end
    mem[3] = 32'h8081_7F00;
    mem[4] = 32'h1122_3344;
    mem[5] = 32'h1122_3344;
    mem[8] = 32'hCAFE_F00D;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (mem_read_signal && mem_write_signal) viol++;
        if (pend && ((mem_read_signal !== p_rd) || (mem_write_signal !== p_wr) ||
                     (mem_adress !== p_a) || (p_wr && (mem_write_data !== p_d)))) viol++;
        pend = (mem_read_signal || mem_write_signal) && !mem_ready;
        p_rd = mem_read_signal;
        p_wr = mem_write_signal;
        p_a  = mem_adress;
        p_d  = mem_write_data;
        if (mem_read_signal && mem_ready) rd_cnt++;
        if (mem_write_signal && mem_ready) begin
          wr_cnt++;
          mem[mem_adress] = mem_write_data;
          last_waddr = mem_adress;
          last_wdata = mem_write_data;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for done; cyc counts cycles from the start cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                        output int cyc, output logic timed_out);
    @(posedge clk); #1;
    start = 1'b1; op = o; address = a; write_data = d;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    timed_out = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  typedef struct {
    logic [2:0]        op;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    int                cyc;
    logic              err;
    logic [31:0]       ld;
    int                nrd;
    int                nwr;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wword;
  } vec_t;

  vec_t vecs[15];

  initial begin : main
    int          cyc;
    logic        to;
    int          rd0;
    int          wr0;
    logic [31:0] ref_mem [256];
    logic [31:0] model_ld;

    vecs[0]  = '{3'd0, 32'h0000_000D, 32'h0,         2, 1'b0, 32'h0000_007F, 1, 0, 8'd0, 32'h0};
    vecs[1]  = '{3'd0, 32'h0000_000E, 32'h0,         2, 1'b0, 32'hFFFF_FF81, 1, 0, 8'd0, 32'h0};
    vecs[2]  = '{3'd3, 32'h0000_000F, 32'h0,         2, 1'b0, 32'h0000_0080, 1, 0, 8'd0, 32'h0};
    vecs[3]  = '{3'd4, 32'h0000_000E, 32'h0,         2, 1'b0, 32'h0000_8081, 1, 0, 8'd0, 32'h0};
    vecs[4]  = '{3'd5, 32'h0000_0011, 32'hAAAA_AAAA, 3, 1'b0, 32'h0000_8081, 1, 1, 8'd4, 32'h1122_AA44};
    vecs[5]  = '{3'd6, 32'h0000_0016, 32'h0000_BEEF, 3, 1'b0, 32'h0000_8081, 1, 1, 8'd5, 32'hBEEF_3344};
    vecs[6]  = '{3'd7, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_8081, 0, 1, 8'd4, 32'hDEAD_BEEF};
    vecs[7]  = '{3'd2, 32'h0000_0005, 32'h0,         1, 1'b1, 32'h0000_8081, 0, 0, 8'd0, 32'h0};
    vecs[8]  = '{3'd1, 32'h0000_0003, 32'h0,         1, 1'b1, 32'h0000_8081, 0, 0, 8'd0, 32'h0};
    vecs[9]  = '{3'd7, 32'h0000_0002, 32'h1234_5678, 1, 1'b1, 32'h0000_8081, 0, 0, 8'd0, 32'h0};
    vecs[10] = '{3'd2, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hDEAD_BEEF, 1, 0, 8'd0, 32'h0};
    vecs[11] = '{3'd1, 32'h0000_000E, 32'h0,         2, 1'b0, 32'hFFFF_8081, 1, 0, 8'd0, 32'h0};
    vecs[12] = '{3'd4, 32'h0000_000C, 32'h0,         2, 1'b0, 32'h0000_7F00, 1, 0, 8'd0, 32'h0};
    vecs[13] = '{3'd2, 32'h0000_040C, 32'h0,         2, 1'b0, 32'h8081_7F00, 1, 0, 8'd0, 32'h0};
    vecs[14] = '{3'd0, 32'h0000_000F, 32'h0,         2, 1'b0, 32'hFFFF_FF80, 1, 0, 8'd0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_load_data", load_data, 0);
    check("rst_strobes", {mem_read_signal, mem_write_signal}, 0);
    rst_n = 1'b1;

    // Reset asserted while a read is stalled
    man_ready = 1'b0;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; address = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    check("midrd_read_high", mem_read_signal, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrd_read_drop", mem_read_signal, 0);
    check("midrd_busy", busy, 0);
    check("midrd_addr", mem_adress, 0);
    check("midrd_outs", {done, error, mem_write_signal}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    man_ready = 1'b1;
    check("midrd_no_access", rd_cnt - rd0, 0);

    // Directed vector table
    foreach (vecs[i]) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, cyc, to);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_error", i), error, vecs[i].err);
      check($sformatf("v%0d_load_data", i), load_data, vecs[i].ld);
      check($sformatf("v%0d_reads", i), rd_cnt - rd0, vecs[i].nrd);
      check($sformatf("v%0d_writes", i), wr_cnt - wr0, vecs[i].nwr);
      if (vecs[i].nwr != 0) begin
        check($sformatf("v%0d_waddr", i), last_waddr, vecs[i].waddr);
        check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].wword);
      end
    end

    // lw with mem_ready low for 3 cycles; start pulses while busy and in DONE are ignored
    man_ready = 1'b0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd2; address = 32'h20; write_data = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = (c == 2);
      op = 3'd7; address = 32'h40; write_data = 32'h5555_5555;
      if (c == 4) man_ready = 1'b1;
      check($sformatf("stall_c%0d_read", c), mem_read_signal, 1);
      check($sformatf("stall_c%0d_addr", c), mem_adress, 8);
    end
    @(posedge clk); #1;
    check("stall_done_c5", done, 1);
    check("stall_load_data", load_data, 32'hCAFE_F00D);
    check("stall_error", error, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("stall_done_start_ignored", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_reads", rd_cnt - rd0, 1);
    check("stall_writes", wr_cnt - wr0, 0);
    check("stall_idle", busy, 0);

    // Randomized traffic with random mem_ready against the reference model
    model_ld = 32'hCAFE_F00D;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    rand_mode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  o;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] w;
      logic [31:0] v;
      int          size;
      int          lane;
      int          idx;
      logic        exp_err;
      int          nrd;
      int          nwr;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      d = $urandom;
      size = (o == 3'd0 || o == 3'd3 || o == 3'd5) ? 1 :
             (o == 3'd1 || o == 3'd4 || o == 3'd6) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(size) - 32'd1);
      lane = int'(a[1:0]);
      idx  = int'(a[9:2]);
      exp_err = (lane % size) != 0;
      nrd = 0;
      nwr = 0;
      if (!exp_err) begin
        w = ref_mem[idx];
        if (o <= 3'd4) begin
          v = w >> (8 * lane);
          if (size == 1) begin
            v = v & 32'hFF;
            if (o == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
          end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (o == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
          end
          model_ld = v;
          nrd = 1;
        end else begin
          for (int b = 0; b < size; b++) w[8 * (lane + b) +: 8] = d[8 * b +: 8];
          ref_mem[idx] = w;
          nrd = (size < 4) ? 1 : 0;
          nwr = 1;
        end
      end
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      run_op(o, a, d, cyc, to);
      check($sformatf("r%0d_timeout", n), to, 0);
      check($sformatf("r%0d_error", n), error, exp_err);
      check($sformatf("r%0d_load_data", n), load_data, model_ld);
      check($sformatf("r%0d_reads", n), rd_cnt - rd0, nrd);
      check($sformatf("r%0d_writes", n), wr_cnt - wr0, nwr);
      if (nwr != 0) check($sformatf("r%0d_mem", n), mem[idx], ref_mem[idx]);
    end
    rand_mode = 1'b0;

    check("protocol_violations", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request from the datapath and drives the word-wide memory port (read/write strobes, word address, write data).
- Sub-word stores (sb/sh) are done as read-modify-write on the 32-bit memory word; the memory never sees partial writes.
- Sub-word loads are lane-extracted and sign- or zero-extended before return.
- Sits between the MIPS datapath/control and the data memory.

Parameters:
ADDR_W, 8, memory word-address width; mem_adress carries word index = address[ADDR_W+1:2].

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request strobe, sampled in IDLE only
op  input  3  0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw
address  input  32  byte address
write_data  input  32  store source (low byte/half used for sb/sh)
busy  output  1  high in every non-IDLE state
done  output  1  one-cycle completion pulse
error  output  1  valid with done; 1 = misaligned, no memory access made
load_data  output  32  extended load result, held until next completed load
mem_adress  output  ADDR_W  word address to memory
mem_write_data  output  32  full word to memory
mem_read_signal  output  1  read strobe
mem_write_signal  output  1  write strobe
mem_read_data  input  32  word from memory
mem_ready  input  1  memory completes the current strobe at this edge

Behaviour:
- Reset (async, while rst_n=0): state IDLE; all outputs 0. Asserting reset mid-operation drops strobes immediately; no write is completed; captured request is discarded.
- FSM states: IDLE, RD, WR, DONE.
- IDLE: on start=1, latch op, address, write_data. Ignore start in all other states, including DONE.
- Alignment check in IDLE at start:
  - lh/lhu/sh require address[0]=0.
  - lw/sw require address[1:0]=0.
  - On failure: go to DONE with error=1; no strobe is ever raised; load_data unchanged.
- Aligned transitions from IDLE: loads and sb/sh go to RD; sw goes to WR.
- RD:
  - mem_read_signal=1, mem_adress = latched word index.
  - Hold until mem_ready=1 at a rising edge; capture mem_read_data at that edge.
  - Loads then go to DONE; sb/sh go to WR.
- WR:
  - mem_write_signal=1; mem_adress stable.
  - mem_write_data: for sw, write_data. For sb/sh, the captured word with the selected lane(s) replaced.
  - Hold until mem_ready=1 at an edge, then go to DONE.
- Strobes: never both high; each stays asserted continuously with stable address/data until its mem_ready edge.
- Lane rules (little-endian):
  - Byte lane = address[1:0], i.e. bits [8k+7:8k].
  - Half lane = address[1], i.e. bits [16h+15:16h].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- DONE: done=1 for exactly one cycle; load_data updated in this cycle for successful loads only; error valid; next state IDLE.
- error stays at its last value until the next done.
- Latency with mem_ready tied 1 (start high in cycle 0):
  - Loads and sw: done in cycle 2.
  - sb/sh: done in cycle 3.
  - Misaligned: done in cycle 1.
- Each wait cycle with mem_ready=0 adds one cycle.
- Back-to-back: the earliest next accepted start is the cycle after DONE.
- address bits above ADDR_W+1 are ignored (wrap on memory size).

Test Plan:
- Reset: assert rst_n=0 mid-RD -> mem_read_signal drops the same cycle; all outputs 0; after release, a start is accepted normally.
- mem[3]=0x8081_7F00; lb 0x0D -> load_data 0x0000_007F; lb 0x0E -> 0xFFFF_FF81; lbu 0x0F -> 0x0000_0080; lhu 0x0E -> 0x0000_8081. Each done in cycle 2 with error=0.
- mem[4]=0x1122_3344; sb 0x11 with write_data 0xAAAA_AAAA, mem_ready tied 1 -> one read then one write of 0x1122_AA44 at word 4; done in cycle 3.
- sh 0x12 with write_data 0x0000_BEEF on mem[4]=0x1122_3344 -> written word 0xBEEF_3344; sw 0x10 with 0xDEAD_BEEF -> no read, single write of 0xDEAD_BEEF.
- Misaligned lw 0x05, lh 0x03, sw 0x02 -> done+error=1 in cycle 1; strobes never high; load_data unchanged.
- mem_ready low for 3 cycles during lw -> mem_read_signal and mem_adress held stable 4 cycles; done in cycle 5. start pulses while busy are ignored (no second access).
